// File: rtl/mdu_iter.sv
// Iterative RV64M multiply/divide unit: radix-2 shift-add multiply, restoring divide.
// Define MDU_EARLY_OUT_EN to let MUL/MULW finish once the remaining multiplier bits are zero.
package mdu_pkg;
  typedef enum logic [3:0] {
    MDU_NOP   = 4'd0,
    MDU_MUL   = 4'd1,
    MDU_MULW  = 4'd2,
    MDU_DIV   = 4'd3,
    MDU_DIVU  = 4'd4,
    MDU_REM   = 4'd5,
    MDU_REMU  = 4'd6,
    MDU_DIVW  = 4'd7,
    MDU_DIVUW = 4'd8,
    MDU_REMW  = 4'd9,
    MDU_REMUW = 4'd10
  } mdu_op_t;
endpackage

module mdu_iter
  import mdu_pkg::*;
#(
  parameter int XLEN = 64,
  parameter int WLEN = 32
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            valid_in,
  input  mdu_op_t         mduop,
  input  logic [XLEN-1:0] srca,
  input  logic [XLEN-1:0] srcb,
  input  logic            flush,
  output logic            ready,
  output logic            done,
  output logic [XLEN-1:0] result
);

`ifdef MDU_EARLY_OUT_EN
  localparam bit EARLY_OUT = 1'b1;
`else
  localparam bit EARLY_OUT = 1'b0;
`endif

  localparam int CW = $clog2(XLEN + 1);
  localparam logic [CW-1:0] N_X = CW'(XLEN);
  localparam logic [CW-1:0] N_W = CW'(WLEN);
  localparam logic [CW-1:0] CNT_ONE = CW'(1);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_BUSY = 2'd1,
    S_DONE = 2'd2
  } state_t;

  typedef struct packed {
    logic vld;
    logic mul;
    logic w;
    logic rem;
    logic sgn;
  } op_info_t;

  function automatic op_info_t decode(input mdu_op_t op);
    op_info_t d;
    d = '0;
    case (op)
      MDU_MUL:   begin d.vld = 1'b1; d.mul = 1'b1; end
      MDU_MULW:  begin d.vld = 1'b1; d.mul = 1'b1; d.w = 1'b1; end
      MDU_DIV:   begin d.vld = 1'b1; d.sgn = 1'b1; end
      MDU_DIVU:  begin d.vld = 1'b1; end
      MDU_REM:   begin d.vld = 1'b1; d.rem = 1'b1; d.sgn = 1'b1; end
      MDU_REMU:  begin d.vld = 1'b1; d.rem = 1'b1; end
      MDU_DIVW:  begin d.vld = 1'b1; d.w = 1'b1; d.sgn = 1'b1; end
      MDU_DIVUW: begin d.vld = 1'b1; d.w = 1'b1; end
      MDU_REMW:  begin d.vld = 1'b1; d.w = 1'b1; d.rem = 1'b1; d.sgn = 1'b1; end
      MDU_REMUW: begin d.vld = 1'b1; d.w = 1'b1; d.rem = 1'b1; end
      default:   d = '0;
    endcase
    return d;
  endfunction

  // Widen a WLEN-bit value, sign- or zero-filling the upper bits.
  function automatic logic [XLEN-1:0] ext_w(input logic [XLEN-1:0] v, input logic sgn);
    return {{(XLEN-WLEN){sgn & v[WLEN-1]}}, v[WLEN-1:0]};
  endfunction

  function automatic logic [XLEN-1:0] fit(input logic [XLEN-1:0] v, input logic w);
    if (w) return ext_w(v, 1'b1);
    else   return v;
  endfunction

  function automatic logic [XLEN-1:0] mag(input logic [XLEN-1:0] v, input logic neg);
    if (neg) return -v;
    else     return v;
  endfunction

  state_t          state_r;
  logic            done_r;
  logic [XLEN-1:0] pend_r;
  logic [XLEN-1:0] result_r;
  logic [CW-1:0]   cnt_r;
  logic            mul_r;
  logic            w_r;
  logic            rem_r;
  logic            neg_q_r;
  logic            neg_r_r;
  logic [XLEN:0]   acc_r;
  logic [XLEN-1:0] a_r;
  logic [XLEN-1:0] b_r;

  op_info_t        in_s;
  logic            accept_s;
  logic [XLEN-1:0] opa_s;
  logic [XLEN-1:0] opb_s;
  logic            sa_s;
  logic            sb_s;
  logic            dvz_s;
  logic            ovf_s;
  logic            special_s;
  logic [XLEN-1:0] special_val_s;
  logic [XLEN-1:0] dvd_s;
  logic [XLEN-1:0] a_init_s;
  logic [XLEN-1:0] b_init_s;

  // Request decode, operand preparation and single-cycle special cases.
  always_comb begin
    in_s          = decode(mduop);
    accept_s      = valid_in && ready && in_s.vld && !flush;
    opa_s         = in_s.w ? ext_w(srca, in_s.sgn) : srca;
    opb_s         = in_s.w ? ext_w(srcb, in_s.sgn) : srcb;
    sa_s          = in_s.sgn & (in_s.w ? srca[WLEN-1] : srca[XLEN-1]);
    sb_s          = in_s.sgn & (in_s.w ? srcb[WLEN-1] : srcb[XLEN-1]);
    dvz_s         = in_s.w ? (srcb[WLEN-1:0] == {WLEN{1'b0}}) : (srcb == {XLEN{1'b0}});
    ovf_s         = 1'b0;
    special_s     = 1'b0;
    special_val_s = {XLEN{1'b0}};
    dvd_s         = {XLEN{1'b0}};
    a_init_s      = {XLEN{1'b0}};
    b_init_s      = {XLEN{1'b0}};

    if (in_s.w) begin
      ovf_s = in_s.sgn && (srca[WLEN-1:0] == {1'b1, {(WLEN-1){1'b0}}})
                       && (srcb[WLEN-1:0] == {WLEN{1'b1}});
    end else begin
      ovf_s = in_s.sgn && (srca == {1'b1, {(XLEN-1){1'b0}}})
                       && (srcb == {XLEN{1'b1}});
    end

    if (in_s.mul) begin
      special_s     = EARLY_OUT && (opb_s == {XLEN{1'b0}});
      special_val_s = {XLEN{1'b0}};
    end else if (dvz_s) begin
      special_s     = 1'b1;
      special_val_s = fit(in_s.rem ? opa_s : {XLEN{1'b1}}, in_s.w);
    end else if (ovf_s) begin
      special_s     = 1'b1;
      special_val_s = fit(in_s.rem ? {XLEN{1'b0}} : opa_s, in_s.w);
    end else begin
      special_s     = 1'b0;
      special_val_s = {XLEN{1'b0}};
    end

    // Division runs on magnitudes; a W dividend is parked in the upper half so
    // that WLEN iterations shift exactly its bits through the remainder.
    if (in_s.mul) begin
      a_init_s = opa_s;
      b_init_s = opb_s;
    end else begin
      dvd_s    = mag(opa_s, sa_s);
      a_init_s = in_s.w ? {dvd_s[WLEN-1:0], {(XLEN-WLEN){1'b0}}} : dvd_s;
      b_init_s = mag(opb_s, sb_s);
    end
  end

  logic [XLEN:0]   rem_sh_s;
  logic            geq_s;
  logic [XLEN:0]   acc_nx_s;
  logic [XLEN-1:0] a_nx_s;
  logic [XLEN-1:0] b_nx_s;
  logic [XLEN-1:0] fin_raw_s;
  logic [XLEN-1:0] fin_s;
  logic            last_s;

  // One multiply or divide step, plus the final sign fix-up of its outcome.
  always_comb begin
    rem_sh_s = {acc_r[XLEN-1:0], a_r[XLEN-1]};
    geq_s    = rem_sh_s >= {1'b0, b_r};
    if (mul_r) begin
      acc_nx_s = b_r[0] ? (acc_r + {1'b0, a_r}) : acc_r;
      a_nx_s   = a_r << 1;
      b_nx_s   = b_r >> 1;
    end else begin
      acc_nx_s = geq_s ? (rem_sh_s - {1'b0, b_r}) : rem_sh_s;
      a_nx_s   = {a_r[XLEN-2:0], geq_s};
      b_nx_s   = b_r;
    end

    if (mul_r)      fin_raw_s = acc_nx_s[XLEN-1:0];
    else if (rem_r) fin_raw_s = mag(acc_nx_s[XLEN-1:0], neg_r_r);
    else            fin_raw_s = mag(a_nx_s, neg_q_r);
    fin_s  = fit(fin_raw_s, w_r);
    last_s = (cnt_r == CNT_ONE) || (EARLY_OUT && mul_r && (b_nx_s == {XLEN{1'b0}}));
  end

  // Control FSM and datapath registers.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_r  <= S_IDLE;
      ready    <= 1'b1;
      done_r   <= 1'b0;
      pend_r   <= {XLEN{1'b0}};
      result_r <= {XLEN{1'b0}};
      cnt_r    <= {CW{1'b0}};
      mul_r    <= 1'b0;
      w_r      <= 1'b0;
      rem_r    <= 1'b0;
      neg_q_r  <= 1'b0;
      neg_r_r  <= 1'b0;
      acc_r    <= {(XLEN+1){1'b0}};
      a_r      <= {XLEN{1'b0}};
      b_r      <= {XLEN{1'b0}};
    end else if (flush) begin
      state_r <= S_IDLE;
      ready   <= 1'b1;
      done_r  <= 1'b0;
      cnt_r   <= {CW{1'b0}};
    end else begin
      case (state_r)
        S_IDLE: begin
          if (accept_s) begin
            mul_r   <= in_s.mul;
            w_r     <= in_s.w;
            rem_r   <= in_s.rem;
            neg_q_r <= sa_s ^ sb_s;
            neg_r_r <= sa_s;
            acc_r   <= {(XLEN+1){1'b0}};
            a_r     <= a_init_s;
            b_r     <= b_init_s;
            ready   <= 1'b0;
            if (special_s) begin
              state_r <= S_DONE;
              pend_r  <= special_val_s;
              done_r  <= 1'b1;
              cnt_r   <= {CW{1'b0}};
            end else begin
              state_r <= S_BUSY;
              done_r  <= 1'b0;
              cnt_r   <= in_s.w ? N_W : N_X;
            end
          end else begin
            ready  <= 1'b1;
            done_r <= 1'b0;
          end
        end
        S_BUSY: begin
          acc_r <= acc_nx_s;
          a_r   <= a_nx_s;
          b_r   <= b_nx_s;
          if (last_s) begin
            state_r <= S_DONE;
            pend_r  <= fin_s;
            done_r  <= 1'b1;
            cnt_r   <= {CW{1'b0}};
          end else begin
            cnt_r  <= cnt_r - CNT_ONE;
            done_r <= 1'b0;
          end
        end
        S_DONE: begin
          state_r  <= S_IDLE;
          ready    <= 1'b1;
          done_r   <= 1'b0;
          result_r <= pend_r;
        end
        default: begin
          state_r <= S_IDLE;
          ready   <= 1'b1;
          done_r  <= 1'b0;
          cnt_r   <= {CW{1'b0}};
        end
      endcase
    end
  end

  // A flush arriving in the DONE cycle cancels the pulse and leaves the old result visible.
  assign done   = done_r & ~flush;
  assign result = done ? pend_r : result_r;

endmodule

// File: tb/tb_mdu_iter.sv
// Self-checking bench for mdu_iter: directed vector table, corner-case sequences and
// randomized operations checked against a plain-arithmetic reference model.
module tb_mdu_iter;
  import mdu_pkg::*;

  localparam logic [63:0] MIN64 = 64'h8000_0000_0000_0000;
  localparam logic [63:0] ONES  = 64'hFFFF_FFFF_FFFF_FFFF;
`ifdef MDU_EARLY_OUT_EN
  localparam int LAT_MULW16 = 7;
`else
  localparam int LAT_MULW16 = 34;
`endif

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        valid_in = 1'b0;
  logic        flush = 1'b0;
  mdu_op_t     mduop = MDU_NOP;
  logic [63:0] srca = 64'd0;
  logic [63:0] srcb = 64'd0;
  logic        ready;
  logic        done;
  logic [63:0] result;

  int n_checks = 0;
  int n_errors = 0;

  typedef struct {
    mdu_op_t     op;
    logic [63:0] a;
    logic [63:0] b;
    logic [63:0] res;
    int          lat;
  } vec_t;

  vec_t    vt[$];
  mdu_op_t ops_l[10];

  mdu_iter #(.XLEN(64), .WLEN(32)) dut (
    .clk(clk), .reset(reset), .valid_in(valid_in), .mduop(mduop),
    .srca(srca), .srcb(srcb), .flush(flush),
    .ready(ready), .done(done), .result(result)
  );

  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%016h expected 0x%016h", nm, act, exp);
    end
  endtask

  function automatic logic [63:0] sx32(input logic [31:0] v);
    return {{32{v[31]}}, v};
  endfunction

  function automatic logic [63:0] ref_res(input mdu_op_t op, input logic [63:0] a, input logic [63:0] b);
    logic signed [63:0] sa, sb;
    logic signed [31:0] wa, wb;
    logic [31:0] ua, ub, p32;
    sa = a; sb = b; wa = a[31:0]; wb = b[31:0]; ua = a[31:0]; ub = b[31:0];
    p32 = ua * ub;
    case (op)
      MDU_MUL:   return a * b;
      MDU_MULW:  return sx32(p32);
      MDU_DIV:   if (b == 64'd0) return ONES;
                 else if (a == MIN64 && b == ONES) return a;
                 else return sa / sb;
      MDU_REM:   if (b == 64'd0) return a;
                 else if (a == MIN64 && b == ONES) return 64'd0;
                 else return sa % sb;
      MDU_DIVU:  if (b == 64'd0) return ONES; else return a / b;
      MDU_REMU:  if (b == 64'd0) return a; else return a % b;
      MDU_DIVW:  if (ub == 32'd0) return ONES;
                 else if (ua == 32'h8000_0000 && ub == 32'hFFFF_FFFF) return sx32(ua);
                 else return sx32(wa / wb);
      MDU_REMW:  if (ub == 32'd0) return sx32(ua);
                 else if (ua == 32'h8000_0000 && ub == 32'hFFFF_FFFF) return 64'd0;
                 else return sx32(wa % wb);
      MDU_DIVUW: if (ub == 32'd0) return ONES; else return sx32(ua / ub);
      MDU_REMUW: if (ub == 32'd0) return sx32(ua); else return sx32(ua % ub);
      default:   return 64'd0;
    endcase
  endfunction

  // Cycles from the accept cycle to the done cycle, inclusive.
  function automatic int ref_lat(input mdu_op_t op, input logic [63:0] a, input logic [63:0] b);
    bit w;
    w = op inside {MDU_MULW, MDU_DIVW, MDU_DIVUW, MDU_REMW, MDU_REMUW};
    if (op == MDU_MUL || op == MDU_MULW) begin
`ifdef MDU_EARLY_OUT_EN
      logic [63:0] m;
      int hi;
      m = w ? {32'd0, b[31:0]} : b;
      if (m == 64'd0) return 2;
      hi = 0;
      for (int i = 0; i < 64; i++) if (m[i]) hi = i;
      return 3 + hi;
`else
      return w ? 34 : 66;
`endif
    end
    if (w ? (b[31:0] == 32'd0) : (b == 64'd0)) return 2;
    if ((op == MDU_DIV || op == MDU_REM) && a == MIN64 && b == ONES) return 2;
    if ((op == MDU_DIVW || op == MDU_REMW) && a[31:0] == 32'h8000_0000 && b[31:0] == 32'hFFFF_FFFF) return 2;
    return w ? 34 : 66;
  endfunction

  task automatic run_op(input mdu_op_t op, input logic [63:0] a, input logic [63:0] b,
                        input logic [63:0] exp_res, input int exp_lat, input string nm);
    int lat;
    @(negedge clk);
    chk({nm, " ready"}, 64'(ready), 64'd1);
    valid_in = 1'b1; mduop = op; srca = a; srcb = b;
    @(negedge clk);
    valid_in = 1'b0; mduop = MDU_NOP;
    lat = 0;
    for (int k = 1; k <= 200; k++) begin
      if (done) begin lat = k + 1; break; end
      @(negedge clk);
    end
    chk({nm, " latency"}, 64'(lat), 64'(exp_lat));
    chk({nm, " result"}, result, exp_res);
    @(negedge clk);
    chk({nm, " hold"}, result, exp_res);
  endtask

  task automatic watch_no_done(input int cycles, input string nm);
    int seen;
    seen = 0;
    for (int k = 0; k < cycles; k++) begin
      @(negedge clk);
      if (done) seen++;
    end
    chk({nm, " no done"}, 64'(seen), 64'd0);
  endtask

  initial begin
    logic [63:0] a, b;
    mdu_op_t op;
    int sel, lat, seen;

    ops_l = '{MDU_MUL, MDU_MULW, MDU_DIV, MDU_DIVU, MDU_REM, MDU_REMU,
              MDU_DIVW, MDU_DIVUW, MDU_REMW, MDU_REMUW};

    vt.push_back('{MDU_MUL,   64'h7, 64'hFFFF_FFFF_FFFF_FFFD, 64'hFFFF_FFFF_FFFF_FFEB, 66});
    vt.push_back('{MDU_DIVW,  64'h0000_0000_8000_0000, ONES, 64'hFFFF_FFFF_8000_0000, 2});
    vt.push_back('{MDU_REMW,  64'h0000_0000_8000_0000, ONES, 64'h0, 2});
    vt.push_back('{MDU_DIVU,  64'h1234, 64'h0, ONES, 2});
    vt.push_back('{MDU_REMU,  64'h1234, 64'h0, 64'h1234, 2});
    vt.push_back('{MDU_REM,   64'hFFFF_FFFF_FFFF_FFF9, 64'h2, ONES, 66});
    vt.push_back('{MDU_DIV,   64'hFFFF_FFFF_FFFF_FFF9, 64'h2, 64'hFFFF_FFFF_FFFF_FFFD, 66});
    vt.push_back('{MDU_DIVUW, 64'd100, 64'd7, 64'd14, 34});
    vt.push_back('{MDU_MULW,  64'hABCD_0000_0800_0001, 64'h10, 64'hFFFF_FFFF_8000_0010, LAT_MULW16});
    vt.push_back('{MDU_DIV,   MIN64, ONES, MIN64, 2});
    vt.push_back('{MDU_REM,   MIN64, ONES, 64'h0, 2});
    vt.push_back('{MDU_DIVW,  64'd5, 64'hFFFF_FFFF_0000_0000, ONES, 2});
    vt.push_back('{MDU_REMUW, 64'h0000_0000_9000_0000, 64'h1_0000_0000, 64'hFFFF_FFFF_9000_0000, 2});
    vt.push_back('{MDU_REMU,  64'd100, 64'd7, 64'd2, 66});
    vt.push_back('{MDU_DIVW,  64'hFFFF_FFFF_FFFF_FF9C, 64'd7, 64'hFFFF_FFFF_FFFF_FFF2, 34});
    vt.push_back('{MDU_REMW,  64'hFFFF_FFFF_FFFF_FF9C, 64'd7, 64'hFFFF_FFFF_FFFF_FFFE, 34});
    vt.push_back('{MDU_DIVU,  ONES, 64'd2, 64'h7FFF_FFFF_FFFF_FFFF, 66});

    // Reset state
    @(negedge clk);
    chk("reset ready", 64'(ready), 64'd1);
    chk("reset done", 64'(done), 64'd0);
    chk("reset result", result, 64'd0);
    @(negedge clk);
    reset = 1'b1;

    foreach (vt[i])
      run_op(vt[i].op, vt[i].a, vt[i].b, vt[i].res, vt[i].lat, $sformatf("vec%0d_%s", i, vt[i].op.name()));

    // Flush in BUSY cycle 10: previous result is 0x7FFF_FFFF_FFFF_FFFF
    @(negedge clk);
    valid_in = 1'b1; mduop = MDU_DIV; srca = 64'd1000; srcb = 64'd3;
    @(negedge clk);
    valid_in = 1'b0; mduop = MDU_NOP;
    seen = 0;
    for (int k = 1; k < 10; k++) begin
      if (done) seen++;
      @(negedge clk);
    end
    flush = 1'b1;
    @(negedge clk);
    flush = 1'b0;
    chk("flush busy ready", 64'(ready), 64'd1);
    chk("flush busy done", 64'(seen) + 64'(done), 64'd0);
    chk("flush busy result", result, 64'h7FFF_FFFF_FFFF_FFFF);
    watch_no_done(70, "flush busy");
    run_op(MDU_DIVUW, 64'd100, 64'd7, 64'd14, ref_lat(MDU_DIVUW, 64'd100, 64'd7), "after flush DIVUW");

    // Flush coinciding with a request in IDLE: nothing accepted
    @(negedge clk);
    valid_in = 1'b1; mduop = MDU_DIV; srca = 64'd50; srcb = 64'd5; flush = 1'b1;
    @(negedge clk);
    valid_in = 1'b0; mduop = MDU_NOP; flush = 1'b0;
    chk("flush+valid ready", 64'(ready), 64'd1);
    watch_no_done(70, "flush+valid");

    // Flush in the DONE cycle of a divide-by-zero
    @(negedge clk);
    valid_in = 1'b1; mduop = MDU_DIVU; srca = 64'h1234; srcb = 64'd0;
    @(negedge clk);
    valid_in = 1'b0; mduop = MDU_NOP;
    flush = 1'b1;
    #1;
    chk("flush done-cycle done", 64'(done), 64'd0);
    chk("flush done-cycle result", result, 64'd14);
    @(negedge clk);
    flush = 1'b0;
    chk("flush done-cycle ready", 64'(ready), 64'd1);
    chk("flush done-cycle kept", result, 64'd14);

    // valid_in held through BUSY: one operation only
    @(negedge clk);
    valid_in = 1'b1; mduop = MDU_REMU; srca = 64'd100; srcb = 64'd7;
    @(negedge clk);
    lat = 0;
    for (int k = 1; k <= 200; k++) begin
      if (done) begin lat = k + 1; break; end
      @(negedge clk);
    end
    valid_in = 1'b0; mduop = MDU_NOP;
    chk("held valid latency", 64'(lat), 64'd66);
    chk("held valid result", result, 64'd2);
    watch_no_done(80, "held valid");
    chk("held valid ready", 64'(ready), 64'd1);

    // Reset in BUSY cycle 5
    @(negedge clk);
    valid_in = 1'b1; mduop = MDU_DIV; srca = 64'd1000; srcb = 64'd3;
    @(negedge clk);
    valid_in = 1'b0; mduop = MDU_NOP;
    repeat (4) @(negedge clk);
    reset = 1'b0;
    #1;
    chk("midreset ready", 64'(ready), 64'd1);
    chk("midreset done", 64'(done), 64'd0);
    chk("midreset result", result, 64'd0);
    @(negedge clk);
    reset = 1'b1;
    watch_no_done(70, "midreset");
    run_op(MDU_MUL, 64'd5, 64'd3, 64'd15, ref_lat(MDU_MUL, 64'd5, 64'd3), "MUL 5x3");

    // Randomized operations against the reference model
    for (int i = 0; i < 40; i++) begin
      op  = ops_l[$urandom_range(0, 9)];
      a   = {$urandom, $urandom};
      b   = {$urandom, $urandom};
      sel = $urandom_range(0, 5);
      case (sel)
        0: b = 64'd0;
        1: begin a = MIN64; b = ONES; end
        2: begin a = 64'hFFFF_FFFF_8000_0000; b = ONES; end
        3: b = 64'($urandom_range(1, 20));
        4: begin a = a >> $urandom_range(0, 63); b = b >> $urandom_range(0, 63); end
        default: ;
      endcase
      run_op(op, a, b, ref_res(op, a, b), ref_lat(op, a, b), $sformatf("rand%0d_%s", i, op.name()));
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/mdu_iter.md
# mdu_iter

Iterative multiply/divide unit for the RV64M extension, sitting inside the execute stage next to the ALU. It consumes the `mdu_op_t` code and the two forwarded source operands of a decoded instruction. It returns a 64-bit result after a multi-cycle shift-add or restoring-division sequence. While it is busy, the execute stage stalls upstream stages.

## Interface
Parameters:
- `XLEN`, 64: operand/result width.
- `WLEN`, 32: width used by the `*W` operations.

Ports:
- `clk`  in  1  clock; all state updates on the rising edge.
- `reset`  in  1  asynchronous, active-low reset.
- `valid_in`  in  1  start request; sampled only when `ready` is 1.
- `mduop`  in  4  `mdu_op_t`. `MDU_NOP` with `valid_in` is ignored.
- `srca`, `srcb`  in  64  operand a (multiplicand/dividend) and operand b (multiplier/divisor).
- `flush`  in  1  abort the current operation.
- `ready`  out  1  1 in IDLE only.
- `done`  out  1  one-cycle pulse; `result` is valid in that cycle.
- `result`  out  64  final value; holds until the next accepted start.

## Operation
- States:
  - IDLE: accept a request.
  - BUSY: iterate.
  - DONE: present the result for one cycle.
- Accept condition: `valid_in && ready && mduop != MDU_NOP && !flush`. On accept:
  - Latch the op and operands.
  - Set the iteration counter N: 64 for MUL/DIV/DIVU/REM/REMU, 32 for the W variants.
  - W variants use `srca[31:0]`/`srcb[31:0]`. DIVW/REMW sign-extend these bits to form the operands; DIVUW/REMUW zero-extend them.
- MUL/MULW:
  - Radix-2 shift-add, one multiplier bit per cycle.
  - Only the low product bits are kept, so operand signedness is irrelevant.
  - MULW result = sign-extension of product bit 31 over bits 63:32.
- DIV/REM (signed):
  - Divide magnitudes with a restoring algorithm, one quotient bit per cycle.
  - Negate the quotient if the operand signs differ.
  - The remainder takes the dividend's sign.
- DIVU/REMU: plain unsigned restoring division.
- W division results are sign-extended from bit 31.
- Special cases, detected at accept; no iteration, next state is DONE:
  - Divide by zero: quotient = all ones (at op width, then sign-extended); remainder = dividend.
  - Signed overflow (most-negative / −1, at op width): quotient = dividend; remainder = 0.
- Transitions:
  - IDLE→BUSY on a normal accept; IDLE→DONE on a special-case accept.
  - BUSY→DONE when the counter reaches 0.
  - DONE→IDLE unconditionally.
  - Any state→IDLE on `flush` (no `done`, `result` unchanged).

## Timing
- Reset values: state IDLE, `ready`=1, `done`=0, `result`=0, counter=0.
- An accept at edge T enters BUSY. There are N BUSY cycles. `done`=1 in the cycle after the edge where the counter hits 0, so `done` is high in cycle T+N+1.
- Latency: 66 cycles for the 64-bit ops and 34 for the W ops, measured from the accept cycle to the `done` cycle inclusive.
- Special cases: `done` in cycle T+1.
- `ready`=0 during BUSY and DONE. A `valid_in` in those cycles is ignored and not queued; the requester must hold it.
- A new accept is possible in the cycle after DONE.
- `flush` and `valid_in` in the same IDLE cycle: flush wins, nothing is accepted.
- `flush` in the DONE cycle suppresses `done`.
- `result` registers update only on the DONE transition.
- Reset asserted mid-operation: immediate return to the reset values, no `done`.

## Configuration
- `MDU_EARLY_OUT_EN`:
  - Defined: in MUL/MULW, when the remaining unshifted multiplier bits are all zero, BUSY→DONE on the next edge. Latency becomes 2 + (index of the highest set multiplier bit + 1). A zero multiplier completes with `done` at T+1.
  - Undefined: fixed latency as in Timing for every op. Division is unaffected either way.

## Test plan
- MUL, srca=0x0000_0000_0000_0007, srcb=0xFFFF_FFFF_FFFF_FFFD → `done` 66 cycles after accept, `result`=0xFFFF_FFFF_FFFF_FFEB.
- DIVW, srca=0x0000_0000_8000_0000, srcb=0xFFFF_FFFF_FFFF_FFFF → overflow path, `done` next cycle, `result`=0xFFFF_FFFF_8000_0000. REMW with the same operands → 0.
- DIVU, srcb=0, srca=0x1234 → `result`=0xFFFF_FFFF_FFFF_FFFF at T+1. REMU with the same operands → 0x1234.
- REM, srca=−7, srcb=2 → `result`=−1 (0xFFFF_FFFF_FFFF_FFFF). DIV with the same operands → −3. Both take 66 cycles.
- Accept DIV, assert `flush` at cycle 10 of BUSY → `ready`=1 next cycle, no `done`, `result` keeps its previous value. A DIVUW of 100/7 issued next → `result`=14.
- `valid_in` held during BUSY → no second accept. `reset` low at BUSY cycle 5 → `ready`=1, `result`=0 immediately. With `MDU_EARLY_OUT_EN`, MUL 5×3 → `done` at cycle 4 with `result`=15.
